limbus_cpu_ocimem_arbiter: RTL and testbench

//  Shares the single-port on-chip debug RAM (OCI mem) between two requesters:
//  - the debug slave's sysclk-side JTAG command path;
//  - the CPU-side Avalon debug_mem slave.

---
 rtl/limbus_cpu_ocimem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_limbus_cpu_ocimem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limbus_cpu_ocimem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// limbus_cpu_ocimem_arbiter - shares the OCI debug RAM between JTAG and Avalon
// Rev 1.0
// ----------------------------------------------------------------------------
module limbus_cpu_ocimem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] C_LAT_M1 = 3'(RAM_LAT - 1);

  state_t            state_q, state_d;
  logic              jtag_pend_q, jtag_pend_d;
  logic              jp_wr_q, jp_wr_d;
  logic [ADDR_W-1:0] jp_addr_q, jp_addr_d;
  logic [DATA_W-1:0] jp_wdata_q, jp_wdata_d;
  logic              last_jtag_q, last_jtag_d;
  logic              op_jtag_q, op_jtag_d;
  logic              op_wr_q, op_wr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [DATA_W-1:0] mon_q, mon_d;
  logic              mon_rdy_q, mon_rdy_d;
  logic              mon_err_q, mon_err_d;
  logic [DATA_W-1:0] avs_rdata_q, avs_rdata_d;
  logic              avs_rdv_q, avs_rdv_d;

  logic              w_idle, w_avs_req, w_jtag_busy, w_jtag_acc, w_jtag_cand;
  logic              w_grant_j, w_grant_a, w_j_wr;
  logic [ADDR_W-1:0] w_j_addr;
  logic [DATA_W-1:0] w_j_wdata;

  // A request accepted in an IDLE cycle competes immediately, not a cycle later.
  assign w_idle      = (state_q == S_IDLE);
  assign w_avs_req   = avs_read | avs_write;
  assign w_jtag_busy = op_jtag_q & ((state_q == S_ISSUE) | (state_q == S_WAIT));
  assign w_jtag_acc  = jtag_req & ~jtag_pend_q & ~w_jtag_busy;
  assign w_jtag_cand = jtag_pend_q | w_jtag_acc;
  assign w_j_wr      = jtag_pend_q ? jp_wr_q    : jtag_wr;
  assign w_j_addr    = jtag_pend_q ? jp_addr_q  : jtag_addr;
  assign w_j_wdata   = jtag_pend_q ? jp_wdata_q : jtag_wdata;
  assign w_grant_j   = w_idle & w_jtag_cand & (~w_avs_req | ~last_jtag_q);
  assign w_grant_a   = w_idle & w_avs_req & ~w_grant_j;

  always_comb begin
    state_d     = state_q;
    jtag_pend_d = jtag_pend_q;
    jp_wr_d     = jp_wr_q;
    jp_addr_d   = jp_addr_q;
    jp_wdata_d  = jp_wdata_q;
    last_jtag_d = last_jtag_q;
    op_jtag_d   = op_jtag_q;
    op_wr_d     = op_wr_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    mon_d       = mon_q;
    mon_rdy_d   = mon_rdy_q;
    mon_err_d   = mon_err_q;
    avs_rdata_d = avs_rdata_q;
    avs_rdv_d   = 1'b0;

    if (w_jtag_acc) begin
      jtag_pend_d = 1'b1;
      jp_wr_d     = jtag_wr;
      jp_addr_d   = jtag_addr;
      jp_wdata_d  = jtag_wdata;
      mon_rdy_d   = 1'b0;
      mon_err_d   = 1'b0;
    end else if (jtag_req) begin
      mon_err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (w_grant_j) begin
          jtag_pend_d = 1'b0;
          last_jtag_d = 1'b1;
          op_jtag_d   = 1'b1;
          op_wr_d     = w_j_wr;
          ram_addr_d  = w_j_addr;
          ram_wdata_d = w_j_wdata;
          ram_we_d    = w_j_wr;
          ram_re_d    = ~w_j_wr;
          state_d     = S_ISSUE;
        end else if (w_grant_a) begin
          last_jtag_d = 1'b0;
          op_jtag_d   = 1'b0;
          op_wr_d     = avs_write;
          ram_addr_d  = avs_address;
          ram_wdata_d = avs_writedata;
          ram_we_d    = avs_write;
          ram_re_d    = avs_read;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_wr_q) begin
          if (op_jtag_q) mon_rdy_d = 1'b1;
          state_d = S_IDLE;
        end else if (RAM_LAT > 1) begin
          cnt_d   = 3'd1;
          state_d = S_WAIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == C_LAT_M1) state_d = S_DONE;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      S_DONE: begin
        // A freshly accepted JTAG request keeps ready low for the new op.
        if (op_jtag_q) begin
          mon_d = ram_rdata;
          if (!w_jtag_acc) mon_rdy_d = 1'b1;
        end else begin
          avs_rdata_d = ram_rdata;
          avs_rdv_d   = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      jtag_pend_q <= 1'b0;
      jp_wr_q     <= 1'b0;
      jp_addr_q   <= '0;
      jp_wdata_q  <= '0;
      last_jtag_q <= 1'b0;
      op_jtag_q   <= 1'b0;
      op_wr_q     <= 1'b0;
      cnt_q       <= 3'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      mon_q       <= '0;
      mon_rdy_q   <= 1'b0;
      mon_err_q   <= 1'b0;
      avs_rdata_q <= '0;
      avs_rdv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      jtag_pend_q <= jtag_pend_d;
      jp_wr_q     <= jp_wr_d;
      jp_addr_q   <= jp_addr_d;
      jp_wdata_q  <= jp_wdata_d;
      last_jtag_q <= last_jtag_d;
      op_jtag_q   <= op_jtag_d;
      op_wr_q     <= op_wr_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      mon_q       <= mon_d;
      mon_rdy_q   <= mon_rdy_d;
      mon_err_q   <= mon_err_d;
      avs_rdata_q <= avs_rdata_d;
      avs_rdv_q   <= avs_rdv_d;
    end
  end

  assign avs_waitrequest   = reset | (w_avs_req & ~w_grant_a);
  assign MonDReg           = mon_q;
  assign monitor_ready     = mon_rdy_q;
  assign monitor_error     = mon_err_q;
  assign avs_readdata      = avs_rdata_q;
  assign avs_readdatavalid = avs_rdv_q;
  assign ram_addr          = ram_addr_q;
  assign ram_wdata         = ram_wdata_q;
  assign ram_we            = ram_we_q;
  assign ram_re            = ram_re_q;

endmodule
`default_nettype wire

// File: tb/tb_limbus_cpu_ocimem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_limbus_cpu_ocimem_arbiter - bench for the OCI debug RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_limbus_cpu_ocimem_arbiter;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int RAM_LAT   = 2;
  localparam int VALID_LAT = RAM_LAT + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              jtag_req = 1'b0, jtag_wr = 1'b0;
  logic [ADDR_W-1:0] jtag_addr = '0;
  logic [DATA_W-1:0] jtag_wdata = '0;
  logic [DATA_W-1:0] MonDReg;
  logic              monitor_ready, monitor_error;
  logic              avs_read = 1'b0, avs_write = 1'b0;
  logic [ADDR_W-1:0] avs_address = '0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  limbus_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .reset(reset),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // RAM environment: fixed read latency, garbage on the data bus when no read is due.
  logic              tb_init = 1'b1;
  logic [DATA_W-1:0] mem  [0:255];
  logic [DATA_W-1:0] pipe [0:3];
  logic [ADDR_W:0]   acc_q [$];

  function automatic logic [DATA_W-1:0] init_val(input int a);
    logic [7:0] b;
    b = 8'(a);
    return (b == 8'h10) ? 32'hDEADBEEF : {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    pipe[0] <= ram_re ? mem[ram_addr] : $urandom;
    for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    if (ram_re || ram_we) acc_q.push_back({ram_we, ram_addr});
  end
  assign ram_rdata = pipe[RAM_LAT-1];

  // Reference model: a flat shadow of RAM contents plus expected Avalon read returns.
  logic [DATA_W-1:0] shadow [0:255];
  logic [DATA_W-1:0] exp_data_q [$];
  int unsigned       exp_cyc_q  [$];
  logic [DATA_W-1:0] exp_mon = '0;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
  end

  initial forever begin
    @(negedge clk);
    if (!reset && avs_readdatavalid) begin
      if (exp_data_q.size() == 0) begin
        check("rdv_unexpected", 32'(avs_readdatavalid), 32'd0);
      end else begin
        check("avs_rdata", avs_readdata, exp_data_q.pop_front());
        check("avs_rd_latency", cyc - exp_cyc_q.pop_front(), VALID_LAT);
      end
    end
  end

  task automatic avs_op(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                        output int waits);
    bit done = 0;
    waits = 0;
    avs_read = !wr; avs_write = wr; avs_address = addr; avs_writedata = data;
    while (!done) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        done = 1;
        if (wr) shadow[addr] = data;
        else begin
          exp_data_q.push_back(shadow[addr]);
          exp_cyc_q.push_back(cyc);
        end
      end else begin
        waits++;
        if (waits > 60) begin
          check("avs_accept_timeout", 32'(avs_waitrequest), 32'd0);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic jtag_op(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    int n = 0;
    logic [31:0] exp_val;
    jtag_req = 1'b1; jtag_wr = wr; jtag_addr = addr; jtag_wdata = data;
    @(posedge clk); #1;
    jtag_req = 1'b0;
    if (wr) begin
      shadow[addr] = data;
      exp_val = exp_mon;
    end else begin
      exp_val = shadow[addr];
      exp_mon = shadow[addr];
    end
    @(negedge clk);
    check("jtag_ready_cleared", 32'(monitor_ready), 32'd0);
    while (!monitor_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("jtag_ready", 32'(monitor_ready), 32'd1);
    if (wr) check("mon_after_wr", MonDReg, exp_val);
    else    check("mon_after_rd", MonDReg, exp_val);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_data_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("avs_drain", exp_data_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    exp_data_q.delete();
    exp_cyc_q.delete();
    exp_mon = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, start, n, rdv_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("rst_MonDReg", MonDReg, 32'd0);
    check("rst_ready", 32'(monitor_ready), 32'd0);
    check("rst_error", 32'(monitor_error), 32'd0);
    check("rst_waitreq", 32'(avs_waitrequest), 32'd1);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_ram_we_re", 32'({ram_we, ram_re}), 32'd0);
    reset = 1'b0; tb_init = 1'b0;
    @(posedge clk); #1;

    // T1: JTAG read of a preloaded word, plus a JTAG write/readback
    start = acc_q.size();
    jtag_op(1'b0, 8'h10, 32'd0);
    check("t1_access_count", acc_q.size() - start, 1);
    check("t1_access", 32'(acc_q[start]), 32'h010);
    check("t1_MonDReg", MonDReg, 32'hDEADBEEF);
    jtag_op(1'b1, 8'h20, 32'hCAFE0001);
    jtag_op(1'b0, 8'h20, 32'd0);

    // T2: Avalon write then read back-to-back
    avs_op(1'b1, 8'h05, 32'h12345678, w0);
    avs_op(1'b0, 8'h05, 32'd0, w1);
    check("t2_wr_waits", w0, 0);
    check("t2_rd_waits", w1, 1);
    drain();

    // T3: simultaneous first requests after reset, then sustained contention
    reset_pulse();
    @(posedge clk); #1;
    start = acc_q.size();
    fork
      begin
        for (int i = 0; i < 3; i++) jtag_op(1'b0, 8'h01, 32'd0);
      end
      begin
        int wa;
        for (int i = 0; i < 3; i++) avs_op(1'b0, 8'h02, 32'd0, wa);
      end
    join
    drain();
    check("t3_access_count", acc_q.size() - start, 6);
    for (int i = 0; i < 6 && start + i < acc_q.size(); i++)
      check("t3_grant_order", 32'(acc_q[start+i]), (i % 2 == 0) ? 32'h001 : 32'h002);

    // T4: JTAG overrun during an in-flight JTAG read
    start = acc_q.size();
    jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h10;
    @(posedge clk); #1;
    jtag_req = 1'b0;
    if (RAM_LAT > 1) begin
      @(posedge clk); #1;
    end
    jtag_req = 1'b1; jtag_addr = 8'h11;
    @(posedge clk); #1;
    jtag_req = 1'b0;
    n = 0;
    while (!monitor_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t4_ready", 32'(monitor_ready), 32'd1);
    check("t4_error", 32'(monitor_error), 32'd1);
    check("t4_MonDReg", MonDReg, shadow[8'h10]);
    check("t4_access_count", acc_q.size() - start, 1);
    exp_mon = shadow[8'h10];
    jtag_op(1'b0, 8'h11, 32'd0);
    check("t4_error_cleared", 32'(monitor_error), 32'd0);

    // T5: asynchronous reset while an Avalon read is in flight
    avs_op(1'b0, 8'h07, 32'd0, w0);
    @(posedge clk);
    #2 reset = 1'b1;
    exp_data_q.delete();
    exp_cyc_q.delete();
    exp_mon = '0;
    #1;
    check("t5_waitreq", 32'(avs_waitrequest), 32'd1);
    check("t5_rdv", 32'(avs_readdatavalid), 32'd0);
    check("t5_ram_addr", 32'(ram_addr), 32'd0);
    check("t5_ram_re", 32'(ram_re), 32'd0);
    check("t5_MonDReg", MonDReg, 32'd0);
    check("t5_ready", 32'(monitor_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rdv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (avs_readdatavalid) rdv_cnt++;
    end
    check("t5_no_late_rdv", rdv_cnt, 0);
    @(posedge clk); #1;
    avs_op(1'b0, 8'h07, 32'd0, w0);
    drain();

    // Randomised mix; JTAG and Avalon use disjoint address windows
    fork
      begin
        int wr_w;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          avs_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, wr_w);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          jtag_op(1'($urandom_range(0, 1)), 8'h80 + 8'($urandom_range(0, 15)), $urandom);
        end
      end
    join
    drain();
    check("rand_no_error", 32'(monitor_error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
